// File: rtl/cla_pkg.sv
// Shared constants and FSM state encoding for the serial
// carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_serial_addsub_if.sv
// Operand/result handshake bundle between a source, the
// serial adder/subtractor and a result sink.
interface cla_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );
endinterface

// File: rtl/cla_slice_4bit.sv
// Combinational 4-bit carry-lookahead slice with group
// generate/propagate outputs.
module cla_slice_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       g_out,
    output logic       p_out,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        p_out = &p;
        cout = g_out | (p_out & cin);
        sum = p ^ c;
    end
endmodule

// File: rtl/cla_serial_addsub.sv
// Multi-cycle adder/subtractor: one CLA slice iterated over
// the operands a nibble per cycle, LSB first.
module cla_serial_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    cla_serial_addsub_if.slave bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] a_nib, b_nib, nib_sum;
    logic                nib_g, nib_p, unused_co;

    cla_slice_4bit u_slice (
        .a     (a_nib),
        .b     (b_nib),
        .cin   (c_q),
        .sum   (nib_sum),
        .g_out (nib_g),
        .p_out (nib_p),
        .cout  (unused_co)
    );

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_RUN;
                    a_d     = bus.op_a;
                    b_d     = bus.sub ? ~bus.op_b : bus.op_b;
                    c_d     = bus.sub;
                    idx_d   = '0;
                    res_d   = '0;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        res_d[i*NIBBLE_W +: NIBBLE_W] = nib_sum;
                    end
                end
                c_d = nib_g | (nib_p & c_q);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    cout_d  = c_d;
                    // overflow judged on the fully written result
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                           && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_serial_addsub.sv
// Scoreboard bench for cla_serial_addsub: directed corner cases,
// backpressure, mid-operation reset and random operands.
module tb_cla_serial_addsub;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    cla_serial_addsub_if #(.WIDTH(W)) ifc ();

    cla_serial_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic s);
        exp_t e;
        int   sa, sb, sr;
        sa = $signed(a);
        sb = $signed(b);
        if (s) begin
            e.res = a - b;
            e.co  = (a >= b);
            sr    = sa - sb;
        end else begin
            e.res = a + b;
            e.co  = ((32'(a) + 32'(b)) >= 32'h10000);
            sr    = sa + sb;
        end
        e.ov = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'(ifc.result), 32'(e.res));
                check("cout", 32'(ifc.cout), 32'(e.co));
                check("ovf", 32'(ifc.ovf), 32'(e.ov));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic ordy);
        int n;
        n = 0;
        while (!ifc.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ifc.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        ifc.op_a = a;
        ifc.op_b = b;
        ifc.sub = s;
        ifc.out_ready = ordy;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(a, b, s));
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int stall);
        exp_t e;
        int   k;
        e = model(a, b, s);
        start_op(a, b, s, stall == 0);
        k = 0;
        while (!ifc.out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 32'(k), 32'd4);
        check("in_ready_busy", 32'(ifc.in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(ifc.out_valid), 32'd1);
            check("hold_in_ready", 32'(ifc.in_ready), 32'd0);
            check("hold_result", 32'(ifc.result), 32'(e.res));
            check("hold_cout", 32'(ifc.cout), 32'(e.co));
            check("hold_ovf", 32'(ifc.ovf), 32'(e.ov));
        end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 32'(ifc.in_ready), 32'd1);
        check("release_valid", 32'(ifc.out_valid), 32'd0);
    endtask

    initial begin
        ifc.in_valid = 1'b0;
        ifc.op_a = '0;
        ifc.op_b = '0;
        ifc.sub = 1'b0;
        ifc.out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_result", 32'(ifc.result), 32'd0);
        check("rst_cout", 32'(ifc.cout), 32'd0);
        check("rst_ovf", 32'(ifc.ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_op(16'h00CC, 16'h0033, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b1, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 0);
        do_op(16'h1234, 16'h1234, 1'b1, 0);
        do_op(16'hA5C3, 16'h3C5A, 1'b0, 5);

        start_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(ifc.out_valid), 32'd0);
        check("abort_in_ready", 32'(ifc.in_ready), 32'd1);
        check("abort_result", 32'(ifc.result), 32'd0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(16'h1111, 16'h2222, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
